// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, false-start and
// framing-error detection, registered one-cycle valid/error pulses.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   state_t           r_state, w_state_nxt;
   logic             r_sync1, r_sync2;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_idx, w_idx_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic [7:0]       r_data, w_data_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_ferr, w_ferr_nxt;
   logic             w_rxs;

   assign w_rxs = r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= rx_in;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = START;
               w_cnt_nxt   = '0;
            end
         end
         START: begin
            // Half-bit delay puts every later sample at the centre of its bit.
            if (r_cnt == HALF_M1) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
                  w_idx_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = w_rxs;
               if (r_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = RECOVER;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RECOVER: begin
            if (w_rxs) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_frame_err = r_ferr;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_uart_rx_byte;

   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [7:0] got_d[$];
   int         got_t[$];
   int         ferr_n = 0;
   int         both_n = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         got_d.push_back(rx_data);
         got_t.push_back(cyc);
      end
      if (rx_frame_err) ferr_n++;
      if (rx_valid && rx_frame_err) both_n++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_d.delete();
      got_t.delete();
      ferr_n = 0;
   endtask

   // Drives one full frame; returns the cycle count at the moment the start bit was driven.
   task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
      t0 = cyc;
      rx_in = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = d[i];
         wait_cyc(CPB);
      end
      rx_in = stop;
      wait_cyc(CPB);
      rx_in = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_in = 1'b1;
      wait_cyc(3);
      n_cmp++;
      if ({rx_data, rx_valid, rx_frame_err, busy} !== 11'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b, need all zero",
                  rx_data, rx_valid, rx_frame_err, busy);
      end
      rst = 1'b0;
      wait_cyc(4);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: busy=%b need 0", busy);
      end
   endtask

   task automatic test_single();
      int t0;
      clear_mon();
      send_frame(8'h61, 1'b1, t0);
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != 1) begin
         n_bad++;
         $display("FAIL single_count: got %0d pulses need 1", got_d.size());
      end else begin
         n_cmp++;
         if (got_d[0] !== 8'h61) begin
            n_bad++;
            $display("FAIL single_data: got %h need 61", got_d[0]);
         end
         n_cmp++;
         if ((got_t[0] - (t0 + 1) < LAT - 1) || (got_t[0] - (t0 + 1) > LAT + 1)) begin
            n_bad++;
            $display("FAIL single_latency: got %0d need %0d+-1", got_t[0] - (t0 + 1), LAT);
         end
      end
      n_cmp++;
      if (ferr_n != 0) begin
         n_bad++;
         $display("FAIL single_ferr: got %0d need 0", ferr_n);
      end
      last_good = 8'h61;
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3] = '{8'h48, 8'h7A, 8'h30};
      int t0;
      clear_mon();
      for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, t0);
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != 3) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d need 3", got_d.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got_d[i] !== bytes[i]) begin
               n_bad++;
               $display("FAIL b2b_data[%0d]: got %h need %h", i, got_d[i], bytes[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (got_t[i] - got_t[i-1] != 10 * CPB) begin
               n_bad++;
               $display("FAIL b2b_spacing[%0d]: got %0d need %0d", i, got_t[i] - got_t[i-1], 10 * CPB);
            end
         end
      end
      last_good = 8'h30;
   endtask

   task automatic test_frame_err();
      int t0;
      clear_mon();
      send_frame(8'h55, 1'b0, t0);
      wait_cyc(2 * CPB);
      n_cmp++;
      if (ferr_n != 1 || got_d.size() != 0) begin
         n_bad++;
         $display("FAIL ferr_pulse: got ferr=%0d valid=%0d need 1/0", ferr_n, got_d.size());
      end
      n_cmp++;
      if (rx_data !== last_good) begin
         n_bad++;
         $display("FAIL ferr_hold: got %h need %h", rx_data, last_good);
      end
      send_frame(8'h41, 1'b1, t0);
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != 1 || rx_data !== 8'h41) begin
         n_bad++;
         $display("FAIL ferr_recover: got n=%0d data=%h need 1/41", got_d.size(), rx_data);
      end
      last_good = 8'h41;
   endtask

   task automatic test_glitch();
      int t0;
      bit saw_busy = 0;
      clear_mon();
      rx_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_cyc(1);
         if (busy) saw_busy = 1;
      end
      rx_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         wait_cyc(1);
         if (busy) saw_busy = 1;
      end
      n_cmp++;
      if (!saw_busy || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_busy: saw_busy=%0d busy_now=%b need 1/0", saw_busy, busy);
      end
      n_cmp++;
      if (got_d.size() != 0 || ferr_n != 0) begin
         n_bad++;
         $display("FAIL glitch_pulses: got valid=%0d ferr=%0d need 0/0", got_d.size(), ferr_n);
      end
      send_frame(8'hB7, 1'b1, t0);
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != 1 || rx_data !== 8'hB7) begin
         n_bad++;
         $display("FAIL glitch_next: got n=%0d data=%h need 1/b7", got_d.size(), rx_data);
      end
      last_good = 8'hB7;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d = 8'hEB;
      int t0;
      clear_mon();
      rx_in = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_in = d[i];
         wait_cyc(CPB);
      end
      rx_in = d[4];
      wait_cyc(CPB / 2);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({rx_data, rx_valid, rx_frame_err, busy} !== 11'h000) begin
         n_bad++;
         $display("FAIL midreset_outputs: got data=%h v=%b fe=%b busy=%b need all zero",
                  rx_data, rx_valid, rx_frame_err, busy);
      end
      rx_in = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2 * CPB);
      n_cmp++;
      if (got_d.size() != 0 || ferr_n != 0) begin
         n_bad++;
         $display("FAIL midreset_pulses: got valid=%0d ferr=%0d need 0/0", got_d.size(), ferr_n);
      end
      send_frame(8'h7F, 1'b1, t0);
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != 1 || rx_data !== 8'h7F) begin
         n_bad++;
         $display("FAIL midreset_next: got n=%0d data=%h need 1/7f", got_d.size(), rx_data);
      end
      last_good = 8'h7F;
   endtask

   task automatic test_break();
      clear_mon();
      rx_in = 1'b0;
      wait_cyc(40 * CPB);
      n_cmp++;
      if (ferr_n != 1 || got_d.size() != 0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL break_err: got ferr=%0d valid=%0d busy=%b need 1/0/1", ferr_n, got_d.size(), busy);
      end
      rx_in = 1'b1;
      wait_cyc(3);
      n_cmp++;
      if (busy !== 1'b0 || rx_data !== last_good) begin
         n_bad++;
         $display("FAIL break_release: got busy=%b data=%h need 0/%h", busy, rx_data, last_good);
      end
   endtask

   // Frame-level model: good stop bit yields that byte, bad stop bit yields one error.
   task automatic test_random();
      logic [7:0] exp_q[$];
      int exp_ferr = 0;
      int t0;
      clear_mon();
      for (int k = 0; k < 30; k++) begin
         logic [7:0] d = 8'($urandom);
         logic stop = ($urandom_range(3) != 0);
         send_frame(d, stop, t0);
         if (stop) begin
            exp_q.push_back(d);
            last_good = d;
         end else begin
            exp_ferr++;
         end
         wait_cyc(stop ? $urandom_range(20) : 4 + $urandom_range(20));
      end
      wait_cyc(4);
      n_cmp++;
      if (got_d.size() != exp_q.size() || ferr_n != exp_ferr) begin
         n_bad++;
         $display("FAIL rand_counts: got valid=%0d ferr=%0d need %0d/%0d",
                  got_d.size(), ferr_n, exp_q.size(), exp_ferr);
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin
               n_bad++;
               $display("FAIL rand_data[%0d]: got %h need %h", i, got_d[i], exp_q[i]);
            end
         end
      end
      n_cmp++;
      if (rx_data !== last_good) begin
         n_bad++;
         $display("FAIL rand_hold: got %h need %h", rx_data, last_good);
      end
   endtask

   task automatic test_exclusive();
      n_cmp++;
      if (both_n != 0) begin
         n_bad++;
         $display("FAIL valid_and_err_same_cycle: got %0d cycles need 0", both_n);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_break();
      test_random();
      test_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
